regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer_if.sv | 53 +++++
 rtl/regfile_sequencer.sv | 154 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// Command / register-file bundle for regfile_sequencer.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready handshake; the register-file side never stalls.
//
// Signals:
//   cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm : command from the environment
//   cmd_ready                                            : sequencer can accept a command
//   rf_addr_r1, rf_addr_r2 / rf_rdata1, rf_rdata2        : two asynchronous read ports
//   rf_addr_w, rf_wdata, rf_we                           : single write port
//   done, result, cmd_count                              : completion status
//
// The master side is the environment: it issues commands and owns the register file.
// The slave side is the sequencer.
interface regfile_sequencer_if #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 3
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [BITS_ADDR-1:0] cmd_rd;
   logic [BITS_ADDR-1:0] cmd_rs1;
   logic [BITS_ADDR-1:0] cmd_rs2;
   logic [BITS_DATA-1:0] cmd_imm;

   logic [BITS_ADDR-1:0] rf_addr_r1;
   logic [BITS_ADDR-1:0] rf_addr_r2;
   logic [BITS_DATA-1:0] rf_rdata1;
   logic [BITS_DATA-1:0] rf_rdata2;
   logic [BITS_ADDR-1:0] rf_addr_w;
   logic [BITS_DATA-1:0] rf_wdata;
   logic                 rf_we;

   logic                 done;
   logic [BITS_DATA-1:0] result;
   logic [15:0]          cmd_count;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      output rf_rdata1, rf_rdata2,
      input  cmd_ready,
      input  rf_addr_r1, rf_addr_r2, rf_addr_w, rf_wdata, rf_we,
      input  done, result, cmd_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      input  rf_rdata1, rf_rdata2,
      output cmd_ready,
      output rf_addr_r1, rf_addr_r2, rf_addr_w, rf_wdata, rf_we,
      output done, result, cmd_count
   );
endinterface

// File: rtl/regfile_sequencer.sv
// Sequences MOVI/ADD/SUB/AND commands against an external 2R1W register file.
// Latency: accept edge to rf_we high is 1 cycle (MOVI) or 3 cycles (ALU ops).
// Backpressure: cmd_ready only in IDLE; commands offered while busy are not queued.
//
// Ports:
//   clk   : single clock, rising edge
//   rst   : synchronous active-high reset (does not touch register-file contents)
//   bus   : regfile_sequencer_if slave modport (command, register-file ports, status)
//
// Flow: IDLE -(MOVI)-> WRITE -> IDLE
//       IDLE -(ALU)--> READ -> EXEC -> WRITE -> IDLE
// All outputs are registers; the FSM and every output live in one always_ff.
module regfile_sequencer #(
   parameter int BITS_DATA = 32,
   parameter int BITS_ADDR = 3
) (
   input  logic               clk,
   input  logic               rst,
   regfile_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   localparam logic [1:0] OP_MOVI = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_AND  = 2'b11;

   state_t               r_state;
   logic [1:0]           r_op;
   logic                 r_cmd_ready;
   logic [BITS_ADDR-1:0] r_addr_r1;
   logic [BITS_ADDR-1:0] r_addr_r2;
   logic [BITS_ADDR-1:0] r_addr_w;
   logic [BITS_DATA-1:0] r_a;
   logic [BITS_DATA-1:0] r_b;
   logic [BITS_DATA-1:0] r_wdata;
   logic                 r_we;
   logic                 r_done;
   logic [BITS_DATA-1:0] r_result;
   logic [15:0]          r_cmd_count;

   logic                 w_accept;

   // Arithmetic wraps modulo 2^BITS_DATA; no carry/borrow is kept.
   function automatic logic [BITS_DATA-1:0] alu(
      input logic [1:0]           op,
      input logic [BITS_DATA-1:0] a,
      input logic [BITS_DATA-1:0] b
   );
      logic [BITS_DATA-1:0] y;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         default: y = a;    // MOVI never reaches the ALU
      endcase
      return y;
   endfunction

   // cmd_ready is high exactly in IDLE, so this is also "IDLE and offered".
   assign w_accept = bus.cmd_valid & r_cmd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_op        <= OP_MOVI;
         r_cmd_ready <= 1'b1;
         r_addr_r1   <= '0;
         r_addr_r2   <= '0;
         r_addr_w    <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_cmd_count <= '0;
      end else begin
         // Write strobe and done are single-cycle pulses by default.
         r_we   <= 1'b0;
         r_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op        <= bus.cmd_op;
                  r_addr_w    <= bus.cmd_rd;
                  r_cmd_ready <= 1'b0;
                  if (bus.cmd_op == OP_MOVI) begin
                     // Immediate goes straight to the write port; the read
                     // addresses are left alone so they do not toggle.
                     r_wdata     <= bus.cmd_imm;
                     r_result    <= bus.cmd_imm;
                     r_we        <= 1'b1;
                     r_done      <= 1'b1;
                     r_cmd_count <= r_cmd_count + 16'd1;
                     r_state     <= S_WRITE;
                  end else begin
                     r_addr_r1 <= bus.cmd_rs1;
                     r_addr_r2 <= bus.cmd_rs2;
                     r_state   <= S_READ;
                  end
               end
            end

            S_READ: begin
               // Sources are sampled here, two edges before the write, so
               // rd == rs1/rs2 always sees the old register value.
               r_a     <= bus.rf_rdata1;
               r_b     <= bus.rf_rdata2;
               // Computing the write data from the same read data lets
               // rf_wdata be valid throughout EXEC, one cycle ahead of rf_we.
               r_wdata <= alu(r_op, bus.rf_rdata1, bus.rf_rdata2);
               r_state <= S_EXEC;
            end

            S_EXEC: begin
               r_result    <= alu(r_op, r_a, r_b);
               r_we        <= 1'b1;
               r_done      <= 1'b1;
               r_cmd_count <= r_cmd_count + 16'd1;
               r_state     <= S_WRITE;
            end

            S_WRITE: begin
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end

            default: begin
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.rf_addr_r1 = r_addr_r1;
   assign bus.rf_addr_r2 = r_addr_r2;
   assign bus.rf_addr_w  = r_addr_w;
   assign bus.rf_wdata   = r_wdata;
   assign bus.rf_we      = r_we;
   assign bus.done       = r_done;
   assign bus.result     = r_result;
   assign bus.cmd_count  = r_cmd_count;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer with a behavioural 8x32 register file.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regfile_sequencer;

   localparam logic [1:0] OP_MOVI = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_AND  = 2'b11;

   logic clk;
   logic rst;

   regfile_sequencer_if #(.BITS_DATA(32), .BITS_ADDR(3)) bus ();

   regfile_sequencer #(.BITS_DATA(32), .BITS_ADDR(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: asynchronous reads, write on rising edge; untouched by rst.
   logic [31:0] rf [8];
   int          we_count;

   assign bus.rf_rdata1 = rf[bus.rf_addr_r1];
   assign bus.rf_rdata2 = rf[bus.rf_addr_r2];

   initial we_count = 0;
   always @(posedge clk) begin
      if (bus.rf_we === 1'b1) begin
         rf[bus.rf_addr_w] <= bus.rf_wdata;
         we_count = we_count + 1;
      end
   end

   int checks;
   int errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp_wdata;
      int          exp_lat;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs [12];

   // Starts at a falling edge in IDLE and ends at the falling edge of the
   // IDLE cycle that follows WRITE.
   task automatic run_cmd(input int idx, input vec_t v);
      int          lat;
      logic        addr_bad;
      logic [2:0]  exp_r1;
      logic [2:0]  exp_r2;
      exp_r1 = (v.op == OP_MOVI) ? bus.rf_addr_r1 : v.rs1;
      exp_r2 = (v.op == OP_MOVI) ? bus.rf_addr_r2 : v.rs2;
      chk($sformatf("v%0d ready", idx), {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = v.op;
      bus.cmd_rd    = v.rd;
      bus.cmd_rs1   = v.rs1;
      bus.cmd_rs2   = v.rs2;
      bus.cmd_imm   = v.imm;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      lat = 1;
      addr_bad = 1'b0;
      while (1) begin
         if (bus.rf_addr_r1 !== exp_r1 || bus.rf_addr_r2 !== exp_r2) addr_bad = 1'b1;
         if (bus.rf_we === 1'b1 || lat >= 8) break;
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d raddr_stable", idx), {31'd0, addr_bad}, 32'd0);
      chk($sformatf("v%0d waddr", idx), {29'd0, bus.rf_addr_w}, {29'd0, v.rd});
      chk($sformatf("v%0d wdata", idx), bus.rf_wdata, v.exp_wdata);
      chk($sformatf("v%0d result", idx), bus.result, v.exp_wdata);
      chk($sformatf("v%0d done", idx), {31'd0, bus.done}, 32'd1);
      chk($sformatf("v%0d count", idx), {16'd0, bus.cmd_count}, {16'd0, v.exp_count});
      @(negedge clk);
      chk($sformatf("v%0d we_after", idx), {31'd0, bus.rf_we}, 32'd0);
      chk($sformatf("v%0d done_after", idx), {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   int we0;

   initial begin
      checks = 0;
      errors = 0;

      vecs[0]  = '{OP_MOVI, 3'd1, 3'd0, 3'd0, 32'd5,         32'd5,         1, 16'd1};
      vecs[1]  = '{OP_MOVI, 3'd2, 3'd0, 3'd0, 32'd7,         32'd7,         1, 16'd2};
      vecs[2]  = '{OP_ADD,  3'd3, 3'd1, 3'd2, 32'd0,         32'd12,        3, 16'd3};
      vecs[3]  = '{OP_MOVI, 3'd1, 3'd0, 3'd0, 32'd0,         32'd0,         1, 16'd4};
      vecs[4]  = '{OP_MOVI, 3'd2, 3'd0, 3'd0, 32'd1,         32'd1,         1, 16'd5};
      vecs[5]  = '{OP_SUB,  3'd4, 3'd1, 3'd2, 32'd0,         32'hFFFFFFFF,  3, 16'd6};
      vecs[6]  = '{OP_MOVI, 3'd5, 3'd0, 3'd0, 32'hF0F0F0F0,  32'hF0F0F0F0,  1, 16'd7};
      vecs[7]  = '{OP_MOVI, 3'd6, 3'd0, 3'd0, 32'hFF00FF00,  32'hFF00FF00,  1, 16'd8};
      vecs[8]  = '{OP_AND,  3'd5, 3'd5, 3'd6, 32'd0,         32'hF000F000,  3, 16'd9};
      vecs[9]  = '{OP_ADD,  3'd7, 3'd5, 3'd5, 32'd0,         32'hE001E000,  3, 16'd10};
      vecs[10] = '{OP_SUB,  3'd0, 3'd4, 3'd3, 32'd0,         32'hFFFFFFF3,  3, 16'd11};
      vecs[11] = '{OP_ADD,  3'd4, 3'd4, 3'd4, 32'd0,         32'hFFFFFFFE,  3, 16'd12};

      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_MOVI;
      bus.cmd_rd    = '0;
      bus.cmd_rs1   = '0;
      bus.cmd_rs2   = '0;
      bus.cmd_imm   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst ready",  {31'd0, bus.cmd_ready}, 32'd1);
      chk("rst we",     {31'd0, bus.rf_we}, 32'd0);
      chk("rst done",   {31'd0, bus.done}, 32'd0);
      chk("rst result", bus.result, 32'd0);
      chk("rst count",  {16'd0, bus.cmd_count}, 32'd0);
      chk("rst wdata",  bus.rf_wdata, 32'd0);
      chk("rst addrs",  {23'd0, bus.rf_addr_r1, bus.rf_addr_r2, bus.rf_addr_w}, 32'd0);

      for (int i = 0; i < 12; i++) run_cmd(i, vecs[i]);

      chk("rf5 after and",   rf[5], 32'hF000F000);
      chk("rf4 after add",   rf[4], 32'hFFFFFFFE);
      chk("rf7 rs1eqrs2",    rf[7], 32'hE001E000);

      // Busy drop: a second command held on cmd_valid during READ/EXEC/WRITE.
      we0 = we_count;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_ADD; bus.cmd_rd = 3'd1; bus.cmd_rs1 = 3'd7; bus.cmd_rs2 = 3'd2;
      @(negedge clk);                                  // READ
      bus.cmd_op = OP_MOVI; bus.cmd_rd = 3'd2; bus.cmd_imm = 32'h0000ABCD;
      chk("busy ready_read", {31'd0, bus.cmd_ready}, 32'd0);
      @(negedge clk);                                  // EXEC
      chk("busy we_exec", {31'd0, bus.rf_we}, 32'd0);
      chk("busy wdata_exec", bus.rf_wdata, 32'hE001E001);
      @(negedge clk);                                  // WRITE of ADD
      chk("busy we_write", {31'd0, bus.rf_we}, 32'd1);
      chk("busy wdata_add", bus.rf_wdata, 32'hE001E001);
      chk("busy waddr_add", {29'd0, bus.rf_addr_w}, 32'd1);
      @(negedge clk);                                  // IDLE, MOVI still offered
      chk("busy ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
      chk("busy we_idle", {31'd0, bus.rf_we}, 32'd0);
      @(negedge clk);                                  // WRITE of MOVI
      bus.cmd_valid = 1'b0;
      chk("busy we_movi", {31'd0, bus.rf_we}, 32'd1);
      chk("busy wdata_movi", bus.rf_wdata, 32'h0000ABCD);
      chk("busy waddr_movi", {29'd0, bus.rf_addr_w}, 32'd2);
      chk("busy count", {16'd0, bus.cmd_count}, 32'd14);
      @(negedge clk);
      chk("busy we_pulses", we_count - we0, 32'd2);

      // Reset while in EXEC, with a command also offered: nothing is written.
      we0 = we_count;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_SUB; bus.cmd_rd = 3'd3; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
      @(negedge clk);                                  // READ
      bus.cmd_valid = 1'b0;
      @(negedge clk);                                  // EXEC
      rst = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_MOVI; bus.cmd_rd = 3'd6; bus.cmd_imm = 32'h5555AAAA;
      @(negedge clk);
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      chk("rstx we", {31'd0, bus.rf_we}, 32'd0);
      chk("rstx done", {31'd0, bus.done}, 32'd0);
      chk("rstx ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rstx count", {16'd0, bus.cmd_count}, 32'd0);
      chk("rstx result", bus.result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rstx no_we", we_count - we0, 32'd0);
      chk("rstx rf3_kept", rf[3], 32'd12);
      chk("rstx rf6_kept", rf[6], 32'hFF00FF00);

      // Counter wrap: 65536 back-to-back MOVIs, cmd_valid held high.
      we0 = we_count;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = OP_MOVI; bus.cmd_rd = 3'd0; bus.cmd_imm = 32'h00001234;
      for (int i = 1; i <= 131071; i++) begin
         @(negedge clk);
         if (i == 131069) chk("wrap count_ffff", {16'd0, bus.cmd_count}, 32'h0000FFFF);
      end
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("wrap count_zero", {16'd0, bus.cmd_count}, 32'd0);
      chk("wrap we_pulses", we_count - we0, 32'd65536);
      chk("wrap ready", {31'd0, bus.cmd_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
